// File: rtl/inst_mem_port_pkg.sv
// Shared fetch-path constants and types: instruction/address widths, enable levels,
// bus idle values and the byte-address helper used by the fetch port.
package inst_mem_port_pkg;

  localparam int INST_ADDR_W    = 32;
  localparam int INST_W         = 32;
  localparam int BYTES_PER_INST = 4;
  localparam int RAM_LAT        = 1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_ADDR_W-1:0] ADDR_FREE = '0;
  localparam logic [INST_W-1:0]      DATA_FREE = '0;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [2:0]             cnt_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Byte address of lane idx within the word at base; wraps modulo 2^32.
  function automatic inst_addr_t byte_addr(input inst_addr_t base, input cnt_t idx);
    return base + inst_addr_t'(idx);
  endfunction

endpackage

// File: rtl/inst_mem_port.sv
// Instruction fetch port: reads one word byte-serially from a shared 8-bit RAM,
// assembles it little-endian and pulses it out together with an icache fill.
module inst_mem_port
  import inst_mem_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        instEn,
  input  logic [31:0] instAddr,
  output logic        memInstOutEn,
  output logic [31:0] memInst,
  input  logic        ramBusy,
  output logic        ramEn,
  output logic [31:0] ramAddr,
  input  logic [7:0]  ramDin,
  output logic        cacheWrEn,
  output logic [31:0] cacheWrAddr,
  output logic [31:0] cacheWrInst,
  output logic        busy
);

  localparam cnt_t NUM_BYTES = cnt_t'(BYTES_PER_INST);
  localparam cnt_t LAST_BYTE = cnt_t'(BYTES_PER_INST - 1);

  logic [0:0] r_state;
  inst_addr_t r_base;
  inst_addr_t r_addr_hold;
  inst_addr_t r_cacheWrAddr;
  logic [23:0] r_asm;
  inst_t      r_memInst;
  cnt_t       r_issueCnt;
  cnt_t       r_rcvCnt;
  logic       r_inflight;
  logic       r_outEn;

  logic       w_reading;
  logic       w_issue;
  logic       w_capture;
  logic       w_last;
  inst_addr_t w_issueAddr;

  assign w_reading   = (r_state == ST_READ);
  // No new read is launched in a reset cycle; its byte would be dropped anyway.
  assign w_issue     = w_reading && !rst && (r_issueCnt < NUM_BYTES) && !ramBusy && rdy;
  assign w_capture   = w_reading && r_inflight;
  assign w_last      = w_capture && (r_rcvCnt == LAST_BYTE);
  assign w_issueAddr = byte_addr(r_base, r_issueCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_base        <= ADDR_FREE;
      r_addr_hold   <= ADDR_FREE;
      r_cacheWrAddr <= ADDR_FREE;
      r_asm         <= '0;
      r_memInst     <= DATA_FREE;
      r_issueCnt    <= '0;
      r_rcvCnt      <= '0;
      r_inflight    <= DISABLE;
      r_outEn       <= DISABLE;
    end else begin
      r_outEn <= DISABLE;
      if (w_issue) begin
        r_addr_hold <= w_issueAddr;
      end
      // A new request always wins: it also drops the byte in flight and any completion.
      if (instEn) begin
        r_state    <= ST_READ;
        r_base     <= instAddr;
        r_issueCnt <= '0;
        r_rcvCnt   <= '0;
        r_inflight <= DISABLE;
      end else if (w_reading) begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_issueCnt <= r_issueCnt + 3'd1;
        end
        if (w_capture) begin
          r_rcvCnt <= r_rcvCnt + 3'd1;
          case (r_rcvCnt[1:0])
            2'd0:    r_asm[7:0]   <= ramDin;
            2'd1:    r_asm[15:8]  <= ramDin;
            2'd2:    r_asm[23:16] <= ramDin;
            default: ;
          endcase
        end
        if (w_last) begin
          r_state       <= ST_IDLE;
          r_outEn       <= ENABLE;
          r_memInst     <= {ramDin, r_asm};
          r_cacheWrAddr <= r_base;
        end
      end
    end
  end

  assign ramEn        = w_issue;
  assign ramAddr      = w_issue ? w_issueAddr : r_addr_hold;
  assign memInstOutEn = r_outEn;
  assign memInst      = r_memInst;
  assign cacheWrEn    = r_outEn;
  assign cacheWrAddr  = r_cacheWrAddr;
  assign cacheWrInst  = r_memInst;
  assign busy         = w_reading;

endmodule

// File: tb/tb_inst_mem_port.sv
// Randomised and directed bench for inst_mem_port: a RAM model feeds bytes, a request-level
// model predicts each fetched word and its completion cycle, a monitor scores the pulses.
`timescale 1ns/1ps
module tb_inst_mem_port;
  import inst_mem_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        instEn;
  logic [31:0] instAddr;
  logic        memInstOutEn;
  logic [31:0] memInst;
  logic        ramBusy;
  logic        ramEn;
  logic [31:0] ramAddr;
  logic [7:0]  ramDin;
  logic        cacheWrEn;
  logic [31:0] cacheWrAddr;
  logic [31:0] cacheWrInst;
  logic        busy;

  always #5 clk = ~clk;

  inst_mem_port dut (
    .clk(clk), .rst(rst), .rdy(rdy), .instEn(instEn), .instAddr(instAddr),
    .memInstOutEn(memInstOutEn), .memInst(memInst), .ramBusy(ramBusy),
    .ramEn(ramEn), .ramAddr(ramAddr), .ramDin(ramDin), .cacheWrEn(cacheWrEn),
    .cacheWrAddr(cacheWrAddr), .cacheWrInst(cacheWrInst), .busy(busy)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  rq[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_n = 0;
  int          pulses = 0;
  int          last_pulse_edge = -1;
  int          prev_pulse_edge = -1;
  logic [31:0] last_word = '0;
  bit          mon_on = 1'b0;

  // Request-level model state
  bit          m_active = 1'b0;
  logic [31:0] m_base = '0;
  logic [31:0] m_hold = '0;
  int          m_issued = 0;
  int          m_fin = -1;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] prog [4];
    logic [31:0] h;
    prog = '{8'h13, 8'h05, 8'h00, 8'h00};
    if (a >= 32'h100 && a <= 32'h103) return prog[a[1:0]];
    h = a * 32'd2654435761;
    return h[31:24];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < BYTES_PER_INST; i++) w[8*i +: 8] = mem_byte(a + 32'(i));
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock cycle: apply inputs, check the combinational RAM side, advance the model
  // to the edge that ends this cycle.
  task automatic step(input logic en, input logic [31:0] a, input logic bz,
                      input logic rd, input logic rs);
    logic exp_issue;
    int   k;
    @(negedge clk);
    if (rq.size() >= RAM_LAT) ramDin = rq.pop_front();
    else ramDin = 8'($urandom);
    instEn = en; instAddr = a; ramBusy = bz; rdy = rd; rst = rs;
    #1;
    rq.push_back(ramEn ? mem_byte(ramAddr) : 8'($urandom));
    k = edge_n + 1;
    exp_issue = m_active && (m_issued < BYTES_PER_INST) && !bz && rd && !rs;
    if (mon_on) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("ramEn", 32'(ramEn), 32'(exp_issue));
      chk("ramAddr", ramAddr, exp_issue ? m_base + 32'(m_issued) : m_hold);
    end
    if (exp_issue) m_hold = m_base + 32'(m_issued);
    if (rs) begin
      if (m_active) void'(sbq.pop_back());
      m_active = 1'b0; m_hold = '0; last_word = '0;
    end else if (en) begin
      if (m_active) void'(sbq.pop_back());
      m_active = 1'b1; m_base = a; m_issued = 0; m_fin = -1;
      sbq.push_back('{word: mem_word(a), addr: a, due: -1});
    end else if (m_active) begin
      if (k == m_fin) m_active = 1'b0;
      else if (exp_issue) begin
        m_issued++;
        if (m_issued == BYTES_PER_INST) begin
          m_fin = k + 1;
          sbq[sbq.size()-1].due = k + 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'($urandom), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_outEn"}, 32'(memInstOutEn), 32'd0);
    chk({tag, "_ramEn"}, 32'(ramEn), 32'd0);
    chk({tag, "_cacheWrEn"}, 32'(cacheWrEn), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_memInst"}, memInst, 32'd0);
    chk({tag, "_cacheWrInst"}, cacheWrInst, 32'd0);
    chk({tag, "_ramAddr"}, ramAddr, 32'd0);
    chk({tag, "_cacheWrAddr"}, cacheWrAddr, 32'd0);
  endtask

  // Monitor: compares every output pulse against the scoreboard head.
  exp_t mon_e;
  bit   mon_exp;
  always @(negedge clk) begin
    if (mon_on) begin
      mon_exp = (sbq.size() > 0) && (sbq[0].due == edge_n);
      chk("memInstOutEn", 32'(memInstOutEn), 32'(mon_exp));
      chk("cacheWrEn", 32'(cacheWrEn), 32'(mon_exp));
      if (memInstOutEn) begin
        pulses++;
        prev_pulse_edge = last_pulse_edge;
        last_pulse_edge = edge_n + 1;
      end
      if (mon_exp) begin
        mon_e = sbq.pop_front();
        chk("memInst", memInst, mon_e.word);
        chk("cacheWrInst", cacheWrInst, mon_e.word);
        chk("cacheWrAddr", cacheWrAddr, mon_e.addr);
        last_word = mon_e.word;
      end else if (!memInstOutEn) begin
        chk("memInst_hold", memInst, last_word);
      end
    end
  end

  int acc;
  int p0;

  initial begin
    rst = 1'b1; instEn = 1'b0; instAddr = '0; ramBusy = 1'b0; rdy = 1'b1; ramDin = '0;
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    mon_on = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_zero_outputs("reset");

    // Basic fetch: 0x100 -> 0x00000513, six cycles
    step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    acc = edge_n + 1;
    idle(8);
    chk("lat_basic", 32'(last_pulse_edge - acc), 32'd6);
    chk("inst_0x100", memInst, 32'h00000513);
    chk("fill_addr_0x100", cacheWrAddr, 32'h100);

    // Three stall cycles after the second issue
    step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    acc = edge_n + 1;
    idle(2);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(8);
    chk("lat_stall", 32'(last_pulse_edge - acc), 32'd9);

    // Redirect two cycles into a request
    p0 = pulses;
    step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("redirect_pulses", 32'(pulses - p0), 32'd1);
    chk("redirect_inst", memInst, mem_word(32'h200));

    // Back-to-back: second request in the pulse cycle
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("b2b_gap", 32'(last_pulse_edge - prev_pulse_edge), 32'd6);
    chk("b2b_inst", memInst, mem_word(32'h4));

    // Reset after the third capture
    p0 = pulses;
    step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_zero_outputs("midreset");
    idle(6);
    chk("midreset_pulses", 32'(pulses - p0), 32'd0);
    step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("after_reset_inst", memInst, 32'h00000513);

    // Address wrap
    step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("wrap_inst", memInst, mem_word(32'hFFFF_FFFE));

    // Random traffic with stalls, redirects and occasional resets
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(15);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
